alu_control: RTL and testbench



---
 rtl/alu_control.sv | 98 +++++++++
 tb/tb_alu_control.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// Registered ALU-operation decoder: maps ALUOp/funct3/funct7[5] to a 4-bit ALU code
// one cycle later, and flags encodings that have no legal meaning.
module alu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [3:0] ALUControl,
    output logic       illegal
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SRA  = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        CLS_ADDR   = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } alu_class_t;

    alu_op_t next_op;
    logic    next_illegal;

    // Operation selected by funct3 alone, shared by R-type and I-type decoding.
    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_op = alt ? OP_SUB : OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = alt ? OP_SRA : OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_op      = OP_ADD;
        next_illegal = 1'b0;
        case (alu_class_t'(ALUOp))
            CLS_ADDR: begin
                next_op      = OP_ADD;
                next_illegal = 1'b0;
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: next_op = OP_SUB;
                    3'b100, 3'b101: next_op = OP_SLT;
                    3'b110, 3'b111: next_op = OP_SLTU;
                    default: begin
                        next_op      = OP_ADD;
                        next_illegal = 1'b1;
                    end
                endcase
            end
            CLS_RTYPE: begin
                next_op      = base_op(funct3, funct7);
                // Only add/sub and the right shifts give funct7[5] a meaning.
                next_illegal = funct7 && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            CLS_ITYPE: begin
                // For addi the funct7 position is immediate data, so it never selects SUB.
                next_op      = base_op(funct3, funct7 && (funct3 == 3'b101));
                next_illegal = funct7 && (funct3 == 3'b001);
            end
            default: begin
                next_op      = OP_ADD;
                next_illegal = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments for registered state avoid simulation race conditions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUControl <= OP_ADD;
            illegal    <= 1'b0;
        end else begin
            ALUControl <= next_op;
            illegal    <= next_illegal;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control: reset, per-class decode vectors,
// latency, hold and mid-stream reset behaviour.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic       funct7;
    logic [3:0] ALUControl;
    logic       illegal;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] exp_ctl;
        logic       exp_ill;
        string      tag;
    } vec_t;

    alu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Advance one rising edge and return on the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [3:0] ctl, input logic ill);
        check({tag, ".ctl"}, ALUControl, ctl);
        check({tag, ".ill"}, {3'b000, illegal}, {3'b000, ill});
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0, "r_sub"},
            '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0, "r_add"},
            '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0, "r_and"},
            '{2'b10, 3'b101, 1'b1, 4'b1001, 1'b0, "r_sra"},
            '{2'b10, 3'b101, 1'b0, 4'b0101, 1'b0, "r_srl"},
            '{2'b10, 3'b110, 1'b1, 4'b0001, 1'b1, "r_or_f7"},
            '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0, "r_or"},
            '{2'b10, 3'b001, 1'b0, 4'b0100, 1'b0, "r_sll"},
            '{2'b10, 3'b010, 1'b0, 4'b0111, 1'b0, "r_slt"},
            '{2'b10, 3'b011, 1'b1, 4'b1000, 1'b1, "r_sltu_f7"},
            '{2'b10, 3'b100, 1'b0, 4'b0011, 1'b0, "r_xor"},
            '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0, "i_addi_f7"},
            '{2'b11, 3'b101, 1'b1, 4'b1001, 1'b0, "i_srai"},
            '{2'b11, 3'b101, 1'b0, 4'b0101, 1'b0, "i_srli"},
            '{2'b11, 3'b001, 1'b1, 4'b0100, 1'b1, "i_slli_f7"},
            '{2'b11, 3'b001, 1'b0, 4'b0100, 1'b0, "i_slli"},
            '{2'b11, 3'b100, 1'b1, 4'b0011, 1'b0, "i_xori_f7"},
            '{2'b11, 3'b011, 1'b1, 4'b1000, 1'b0, "i_sltiu_f7"},
            '{2'b11, 3'b010, 1'b0, 4'b0111, 1'b0, "i_slti"},
            '{2'b11, 3'b110, 1'b0, 4'b0001, 1'b0, "i_ori"},
            '{2'b11, 3'b111, 1'b1, 4'b0000, 1'b0, "i_andi_f7"},
            '{2'b01, 3'b001, 1'b0, 4'b0110, 1'b0, "b_bne"},
            '{2'b01, 3'b000, 1'b1, 4'b0110, 1'b0, "b_beq"},
            '{2'b01, 3'b101, 1'b0, 4'b0111, 1'b0, "b_bge"},
            '{2'b01, 3'b100, 1'b0, 4'b0111, 1'b0, "b_blt"},
            '{2'b01, 3'b111, 1'b0, 4'b1000, 1'b0, "b_bgeu"},
            '{2'b01, 3'b110, 1'b1, 4'b1000, 1'b0, "b_bltu"},
            '{2'b01, 3'b011, 1'b0, 4'b0010, 1'b1, "b_bad011"},
            '{2'b01, 3'b010, 1'b1, 4'b0010, 1'b1, "b_bad010"},
            '{2'b00, 3'b101, 1'b1, 4'b0010, 1'b0, "a_add"}
        };

        rst_n  = 1'b0;
        ALUOp  = 2'b10;
        funct3 = 3'b111;
        funct7 = 1'b0;

        step();
        check_out("rst_edge1", 4'b0010, 1'b0);
        step();
        check_out("rst_edge2", 4'b0010, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("rst_release_and", 4'b0000, 1'b0);

        ALUOp  = 2'b00;
        funct3 = 3'bxxx;
        funct7 = 1'bx;
        step();
        check_out("addr_x", 4'b0010, 1'b0);

        foreach (vecs[i]) begin
            ALUOp  = vecs[i].op;
            funct3 = vecs[i].f3;
            funct7 = vecs[i].f7;
            step();
            check_out(vecs[i].tag, vecs[i].exp_ctl, vecs[i].exp_ill);
        end

        // Hold: stable inputs keep the registered result across several edges.
        ALUOp  = 2'b10;
        funct3 = 3'b100;
        funct7 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("hold_xor_f7", 4'b0011, 1'b1);
        end

        // Latency: inputs changed just after an edge must not appear until the next edge.
        ALUOp  = 2'b00;
        funct3 = 3'b000;
        funct7 = 1'b0;
        step();
        check_out("lat_base", 4'b0010, 1'b0);
        @(posedge clk);
        #1;
        ALUOp  = 2'b10;
        funct3 = 3'b000;
        funct7 = 1'b1;
        #2;
        check_out("lat_before_edge", 4'b0010, 1'b0);
        @(negedge clk);
        check_out("lat_still_old", 4'b0010, 1'b0);
        step();
        check_out("lat_after_edge", 4'b0110, 1'b0);

        // Mid-stream reset with an illegal-producing input present.
        funct3 = 3'b110;
        rst_n  = 1'b0;
        step();
        check_out("mid_reset", 4'b0010, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("post_reset_decode", 4'b0001, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
